// File: rtl/loader_pkg.sv
// Shared types for the UART sample loader: FSM states, error codes and the
// default frame start marker.
package loader_pkg;

    typedef enum logic [2:0] {
        HUNT,
        SLOT,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_SLOT = 2'd0,
        ERR_LEN  = 2'd1,
        ERR_CSUM = 2'd2
    } err_code_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_sample_loader_if.sv
// UART receive handshake plus sample RAM write port of the sample loader.
// master = loader side, slave = pins / RAM side.
interface uart_sample_loader_if #(
    parameter int NUM_SLOTS = 4,
    parameter int ADDR_W    = 12
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [7:0]        rxdata;
    logic              rxready;
    logic              rxclk;
    logic              wr_en;
    logic [SLOT_W-1:0] wr_slot;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        input  rxdata, rxready,
        output rxclk, wr_en, wr_slot, wr_addr, wr_data
    );

    modport slave (
        output rxdata, rxready,
        input  rxclk, wr_en, wr_slot, wr_addr, wr_data
    );

endinterface

// File: rtl/uart_sample_loader_rx_byte_take.sv
// Level-to-pulse byte handshake: one take per rxready high period, with a
// one-cycle rxclk acknowledge following each take.
module rx_byte_take (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rxdata,
    input  logic       rxready,
    output logic       rxclk,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic ack_pending;

    // The take is presented on the same cycle so the FSM's registered outputs
    // line up with rxclk; rxdata is stable while rxready is high.
    assign byte_valid = rxready && !ack_pending;
    assign byte_data  = rxdata;

    // NOTE: state is updated with non-blocking assignments so every always_ff
    // sees the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_pending <= 1'b0;
            rxclk       <= 1'b0;
        end else begin
            rxclk <= byte_valid;
            if (byte_valid)
                ack_pending <= 1'b1;
            else if (!rxready)
                ack_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_sample_loader.sv
// Framed UART sample image loader writing into one of NUM_SLOTS sample RAMs.
// Define LOADER_CHECKSUM_EN to require and check the trailing checksum byte.
module uart_sample_loader
    import loader_pkg::*;
#(
    parameter int         NUM_SLOTS = 4,
    parameter int         ADDR_W    = 12,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_sample_loader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W:0]      done_len,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              rxclk_w;

    loader_state_t     state;
    logic [7:0]        len_hi;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_inc;
    logic [15:0]       len16;
    logic              len_bad;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    logic              wr_en_q;
    logic [SLOT_W-1:0] wr_slot_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    err_code_t         err_code_q;

    rx_byte_take u_take (
        .clk        (clk),
        .reset      (reset),
        .rxdata     (bus.rxdata),
        .rxready    (bus.rxready),
        .rxclk      (rxclk_w),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    assign count_inc = count + (ADDR_W+1)'(1);
    assign len16     = {len_hi, byte_data};
    assign len_bad   = (len16 == 16'd0) || ({1'b0, len16} > MAX_LEN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            busy       <= 1'b0;
            len_hi     <= '0;
            len        <= '0;
            count      <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
            wr_en_q    <= 1'b0;
            wr_slot_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done       <= 1'b0;
            done_len   <= '0;
            err        <= 1'b0;
            err_code_q <= ERR_SLOT;
        end else begin
            wr_en_q <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            if (byte_valid) begin
                case (state)
                    HUNT: begin
                        if (byte_data == SYNC_BYTE) begin
                            state <= SLOT;
                            busy  <= 1'b1;
                        end
                    end
                    SLOT: begin
                        if (int'(byte_data) >= NUM_SLOTS) begin
                            err        <= 1'b1;
                            err_code_q <= ERR_SLOT;
                            state      <= HUNT;
                            busy       <= 1'b0;
                        end else begin
                            wr_slot_q <= byte_data[SLOT_W-1:0];
                            state     <= LEN_HI;
                        end
                    end
                    LEN_HI: begin
                        len_hi <= byte_data;
                        state  <= LEN_LO;
                    end
                    LEN_LO: begin
                        if (len_bad) begin
                            err        <= 1'b1;
                            err_code_q <= ERR_LEN;
                            state      <= HUNT;
                            busy       <= 1'b0;
                        end else begin
                            len   <= len16[ADDR_W:0];
                            count <= '0;
`ifdef LOADER_CHECKSUM_EN
                            csum  <= '0;
`endif
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= count[ADDR_W-1:0];
                        wr_data_q <= byte_data;
                        count     <= count_inc;
`ifdef LOADER_CHECKSUM_EN
                        csum      <= csum + byte_data;
                        if (count_inc == len)
                            state <= CSUM;
`else
                        if (count_inc == len) begin
                            done     <= 1'b1;
                            done_len <= len;
                            state    <= HUNT;
                            busy     <= 1'b0;
                        end
`endif
                    end
`ifdef LOADER_CHECKSUM_EN
                    CSUM: begin
                        // Bytes already written stay in the RAM on a mismatch.
                        if (byte_data == csum) begin
                            done     <= 1'b1;
                            done_len <= len;
                        end else begin
                            err        <= 1'b1;
                            err_code_q <= ERR_CSUM;
                        end
                        state <= HUNT;
                        busy  <= 1'b0;
                    end
`endif
                    default: begin
                        state <= HUNT;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rxclk   = rxclk_w;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_slot = wr_slot_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_uart_sample_loader.sv
// Directed bench for uart_sample_loader; expectations follow LOADER_CHECKSUM_EN.
module tb_uart_sample_loader;
    import loader_pkg::*;

    localparam int NUM_SLOTS = 4;
    localparam int ADDR_W    = 12;

    logic            clk = 1'b0;
    logic            reset;
    logic            busy, done, err;
    logic [ADDR_W:0] done_len;
    logic [1:0]      err_code;

    uart_sample_loader_if #(.NUM_SLOTS(NUM_SLOTS), .ADDR_W(ADDR_W)) bus ();

    uart_sample_loader #(.NUM_SLOTS(NUM_SLOTS), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .done_len (done_len),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int              n_rxclk, n_done, n_err, n_misalign;
    logic [ADDR_W:0] last_len;
    logic [1:0]      last_code;
    logic [7:0]        wr_d_q[$];
    logic [ADDR_W-1:0] wr_a_q[$];
    logic [1:0]        wr_s_q[$];
    logic [7:0]        none[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.rxclk) n_rxclk++;
            if (bus.wr_en) begin
                wr_d_q.push_back(bus.wr_data);
                wr_a_q.push_back(bus.wr_addr);
                wr_s_q.push_back(bus.wr_slot);
            end
            if (done) begin
                n_done++;
                last_len = done_len;
            end
            if (err) begin
                n_err++;
                last_code = err_code;
            end
            if ((bus.wr_en || done || err) && !bus.rxclk) n_misalign++;
        end
    end

    task automatic clear_log();
        n_rxclk = 0;
        n_done  = 0;
        n_err   = 0;
        wr_d_q.delete();
        wr_a_q.delete();
        wr_s_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        bus.rxdata  = b;
        bus.rxready = 1'b1;
        repeat (hold) @(negedge clk);
        bus.rxready = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_seq(input logic [7:0] seq[$], input int hold);
        foreach (seq[i]) send_byte(seq[i], hold);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int exp_rx, input logic [7:0] exp_d[$],
                               input int exp_slot, input int exp_done, input int exp_len,
                               input int exp_err, input int exp_code);
        check({tag, ".rxclk"}, n_rxclk, exp_rx);
        check({tag, ".nwr"}, wr_d_q.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < wr_d_q.size(); i++) begin
            check($sformatf("%s.addr%0d", tag, i), 32'(wr_a_q[i]), i);
            check($sformatf("%s.data%0d", tag, i), 32'(wr_d_q[i]), 32'(exp_d[i]));
            check($sformatf("%s.slot%0d", tag, i), 32'(wr_s_q[i]), exp_slot);
        end
        check({tag, ".ndone"}, n_done, exp_done);
        if (exp_done > 0) check({tag, ".done_len"}, 32'(last_len), exp_len);
        check({tag, ".nerr"}, n_err, exp_err);
        if (exp_err > 0) check({tag, ".err_code"}, 32'(last_code), exp_code);
        check({tag, ".busy"}, 32'(busy), 0);
    endtask

    initial begin
        logic [7:0] seq[$];
        logic [7:0] exp[$];

        n_misalign  = 0;
        bus.rxdata  = 8'h00;
        bus.rxready = 1'b0;
        reset       = 1'b1;
        clear_log();
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        check("rst.err", 32'(err), 0);
        check("rst.rxclk", 32'(bus.rxclk), 0);
        check("rst.wr_en", 32'(bus.wr_en), 0);
        check("rst.wr_addr", 32'(bus.wr_addr), 0);
        check("rst.wr_data", 32'(bus.wr_data), 0);
        check("rst.wr_slot", 32'(bus.wr_slot), 0);
        check("rst.done_len", 32'(done_len), 0);
        check("rst.err_code", 32'(err_code), 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic frame; the trailing 60 is the checksum or, without it, hunted noise.
        clear_log();
        seq = '{8'hA5, 8'h01, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
        exp = '{8'h10, 8'h20, 8'h30};
        send_seq(seq, 1);
        check_frame("frameA", 8, exp, 1, 1, 3, 0, 0);
        check("frameA.hold_slot", 32'(bus.wr_slot), 1);
        check("frameA.hold_addr", 32'(bus.wr_addr), 2);
        check("frameA.hold_data", 32'(bus.wr_data), 32'h30);

        clear_log();
        seq = '{8'h00, 8'hFF, 8'hA4, 8'hA5, 8'h01, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
        send_seq(seq, 1);
        check_frame("noise", 11, exp, 1, 1, 3, 0, 0);

        clear_log();
        seq = '{8'hA5, 8'h04};
        send_seq(seq, 1);
        check_frame("badslot", 2, none, 0, 0, 0, 1, 32'(ERR_SLOT));

        clear_log();
        seq = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h7F, 8'h7F};
        exp = '{8'h7F};
        send_seq(seq, 1);
        check_frame("len1", 6, exp, 0, 1, 1, 0, 0);

        clear_log();
        seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq(seq, 1);
        check_frame("len0", 4, none, 0, 0, 0, 1, 32'(ERR_LEN));

        clear_log();
        seq = '{8'hA5, 8'h00, 8'h10, 8'h01};
        send_seq(seq, 1);
        check_frame("len4097", 4, none, 0, 0, 0, 1, 32'(ERR_LEN));

        // Maximum length: data i[7:0] for 0..4095 sums to 0 mod 256.
        clear_log();
        seq = '{8'hA5, 8'h00, 8'h10, 8'h00};
        foreach (seq[i]) send_byte(seq[i], 1);
        for (int i = 0; i < 4096; i++) send_byte(8'(i), 1);
        send_byte(8'h00, 1);
        repeat (2) @(negedge clk);
        check("max.rxclk", n_rxclk, 4101);
        check("max.nwr", wr_d_q.size(), 4096);
        if (wr_d_q.size() == 4096) begin
            check("max.first_addr", 32'(wr_a_q[0]), 0);
            check("max.last_addr", 32'(wr_a_q[4095]), 32'hFFF);
            check("max.last_data", 32'(wr_d_q[4095]), 32'hFF);
            check("max.mid_data", 32'(wr_d_q[1234]), 32'hD2);
        end
        check("max.ndone", n_done, 1);
        check("max.done_len", 32'(last_len), 4096);
        check("max.nerr", n_err, 0);

        clear_log();
        seq = '{8'hA5, 8'h02, 8'h00, 8'h02, 8'h01, 8'h02, 8'h04};
        exp = '{8'h01, 8'h02};
        send_seq(seq, 1);
`ifdef LOADER_CHECKSUM_EN
        check_frame("badcsum", 7, exp, 2, 0, 0, 1, 32'(ERR_CSUM));
`else
        check_frame("badcsum", 7, exp, 2, 1, 2, 0, 0);
`endif

        clear_log();
        seq = '{8'hA5, 8'h01, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
        exp = '{8'h10, 8'h20, 8'h30};
        send_seq(seq, 10);
        check_frame("hold10", 8, exp, 1, 1, 3, 0, 0);

        // Reset after two data bytes of a five-byte frame.
        clear_log();
        seq = '{8'hA5, 8'h03, 8'h00, 8'h05, 8'h11, 8'h22};
        foreach (seq[i]) send_byte(seq[i], 1);
        check("midrst.busy_before", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("midrst.busy", 32'(busy), 0);
        check("midrst.wr_en", 32'(bus.wr_en), 0);
        check("midrst.nwr", wr_d_q.size(), 2);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst.ndone", n_done, 0);
        check("midrst.nerr", n_err, 0);

        clear_log();
        seq = '{8'hA5, 8'h03, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h65};
        exp = '{8'hAA, 8'hBB};
        send_seq(seq, 1);
        check_frame("afterrst", 7, exp, 3, 1, 2, 0, 0);

        check("align", n_misalign, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
